// File: rtl/if_id_pkg.sv
// Shared constants for the IF/ID skid buffer: default widths, the NOP
// instruction and the occupancy encodings.
package if_id_pkg;

  localparam int          PC_W_DEF      = 16;
  localparam int          INSTR_W_DEF   = 16;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // The buffer state is the pair of valid bits; (main=0, skid=1) is unreachable.
  function automatic occ_e occ_of(input logic main_valid, input logic skid_valid);
    occ_e occ;
    occ = OCC_EMPTY;
    if (main_valid && skid_valid) occ = OCC_FULL;
    else if (main_valid)          occ = OCC_ONE;
    return occ;
  endfunction

endpackage

// File: rtl/if_id_entry.sv
// One buffer slot: valid + PC + instruction with load enable and clear.
// Reset and clear both restore valid=0, PC=0, instruction=NOP.
module if_id_entry
  import if_id_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic               d_valid,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clr) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = d_valid;
      pc_d    = d_pc;
      instr_d = d_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/if_id_skid.sv
// Two-entry skid buffer between fetch and decode. Optional decode-stall
// counter output stall_cnt is enabled by defining IF_ID_STALL_CNT_EN.
module if_id_skid
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 PC_W      = PC_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  logic               main_valid, skid_valid;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;

  logic               main_load, main_clr, main_from_skid;
  logic               skid_load, skid_clr;
  logic [PC_W-1:0]    main_d_pc;
  logic [INSTR_W-1:0] main_d_instr;
  logic               push, pop;
  occ_e               occ;

  // Handshake: a beat transfers on a side only in a cycle where both valid
  // and ready are high at the rising edge. in_ready depends on state alone,
  // so there is no combinational path from out_ready back to fetch.
  assign occ      = occ_of(main_valid, skid_valid);
  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;
  assign pop      = main_valid && out_ready;

  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: main_load = push;
        OCC_ONE: begin
          if (pop) begin
            if (push) main_load = 1'b1;
            else      main_clr  = 1'b1;
          end else if (push) begin
            skid_load = 1'b1;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_d_pc    = main_from_skid ? skid_pc    : in_pc;
  assign main_d_instr = main_from_skid ? skid_instr : in_instr;

  if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (main_clr),
    .load    (main_load),
    .d_valid (1'b1),
    .d_pc    (main_d_pc),
    .d_instr (main_d_instr),
    .valid   (main_valid),
    .pc      (main_pc),
    .instr   (main_instr)
  );

  if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (skid_clr),
    .load    (skid_load),
    .d_valid (1'b1),
    .d_pc    (in_pc),
    .d_instr (in_instr),
    .valid   (skid_valid),
    .pc      (skid_pc),
    .instr   (skid_instr)
  );

  assign out_valid = main_valid;
  assign out_pc    = main_valid ? main_pc    : '0;
  assign out_instr = main_valid ? main_instr : NOP_INSTR;
  assign occupancy = occ;

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts decode-stall cycles; saturates and survives flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: reset checks, a vector table with hand-derived
// occupancy, multi-cycle corner sequences and a randomised FIFO scoreboard.
module tb_if_id_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic [1:0]  occupancy;
`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  if_id_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .occupancy (occupancy)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Scoreboard: entries are {pc, instr} in acceptance order
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt;
  int          errors;
  int          checks;
  logic        seen_4444;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] pc;
    logic [15:0] ins;
    logic        ordy;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, compare outputs against the model, then advance the model.
  task automatic cycle(input logic fl, input logic iv, input logic [15:0] pc,
                       input logic [15:0] ins, input logic ordy);
    logic [31:0] head;
    int          sz;
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    #1;
    sz   = exp_q.size();
    head = {16'h0000, 16'h0800};
    if (sz > 0) head = exp_q[0];
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("in_ready",  32'(in_ready),  32'(sz < 2));
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("out_pc",    32'(out_pc),    32'(head[31:16]));
    chk("out_instr", 32'(out_instr), 32'(head[15:0]));
`ifdef IF_ID_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
`endif
    if (out_valid && out_instr == 16'h4444) seen_4444 = 1'b1;
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      if (sz > 0 && !ordy && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (sz > 0 && ordy) void'(exp_q.pop_front());
        if (iv && sz < 2) exp_q.push_back({pc, ins});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    seen_4444 = 1'b0;
    exp_cnt   = '0;

    // Reset held two cycles with fetch offering an instruction
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 16'h00AA;
    in_instr  = 16'hBEEF;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_instr", 32'(out_instr), 32'h0800);
    chk("reset_out_pc",    32'(out_pc),    32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
`ifdef IF_ID_STALL_CNT_EN
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Streaming, stall fill with refused third offer, flush collision
    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 16'hA000, 1'b1, 2'd1};
    vecs[1]  = '{1'b0, 1'b1, 16'h0002, 16'hA002, 1'b1, 2'd1};
    vecs[2]  = '{1'b0, 1'b1, 16'h0004, 16'hA004, 1'b1, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0010, 16'h1111, 1'b0, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 16'h0012, 16'h2222, 1'b0, 2'd2};
    vecs[6]  = '{1'b0, 1'b1, 16'h0014, 16'h3333, 1'b0, 2'd2};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 16'h0014, 16'h3333, 1'b1, 2'd1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0};
    vecs[10] = '{1'b0, 1'b1, 16'h0020, 16'h6666, 1'b0, 2'd1};
    vecs[11] = '{1'b0, 1'b1, 16'h0022, 16'h7777, 1'b0, 2'd2};
    vecs[12] = '{1'b1, 1'b1, 16'h0024, 16'h4444, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2'd0};
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy);
      chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].exp_occ));
    end
    chk("flush_out_instr_nop", 32'(out_instr), 32'h0800);
    chk("flush_4444_absent",   32'(seen_4444), 32'd0);

    // Reset in state ONE with a push pending, then resume
    cycle(1'b0, 1'b1, 16'h0030, 16'h8888, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 16'h0032, 16'h9999, 1'b1);
    rst = 1'b0;
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_out_instr", 32'(out_instr), 32'h0800);
    cycle(1'b0, 1'b1, 16'h0034, 16'h5555, 1'b0);
    chk("resume_out_valid", 32'(out_valid), 32'd1);
    chk("resume_out_instr", 32'(out_instr), 32'h5555);
    chk("resume_out_pc",    32'(out_pc),    32'h0034);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

`ifdef IF_ID_STALL_CNT_EN
    // Stall counter: five stall cycles, flush keeps it, reset clears it
    rst = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 1'b1, 16'h0040, 16'hAAAA, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("stall_cnt_five", 32'(stall_cnt), 32'd5);
    cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("stall_cnt_after_flush", 32'(stall_cnt), 32'd5);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;
    chk("stall_cnt_after_rst", 32'(stall_cnt), 32'd0);
`endif

    // Randomised traffic against the FIFO model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
